// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one load or store at a time against a
// single-ported word memory. Sub-word stores are done as read-modify-write.
// Loads are extended per op; misaligned accesses complete at once with an
// error flag and no memory traffic.
//
// Handshake: req is taken only while the block is IDLE (busy=0). The access
// is latched on that edge, busy stays high until the cycle after the done
// pulse, and any req seen while busy (including the DONE cycle) is dropped
// rather than queued. done is a single-cycle pulse; misalign and rdata are
// meaningful in the done cycle.
module mem_access_ctrl #(
  parameter int DEPTH_BITS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] dir,
  output logic [31:0] dataInput,
  input  logic [31:0] result,
  output logic [1:0]  state_dbg
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2:0]            op_q;
  logic [DEPTH_BITS+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  mis_q;
  logic [31:0]           merged_q;
  logic                  accept;

  // Upper address bits never reach the word index.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:DEPTH_BITS+2];

  // Word/halfword accesses must sit on their natural boundary.
  function automatic logic is_misaligned(input logic [2:0] o, input logic [1:0] a);
    logic m;
    m = 1'b0;
    case (o)
      OP_LW, OP_SW:         m = (a != 2'b00);
      OP_LH, OP_LHU, OP_SH: m = a[0];
      default:              m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic is_load(input logic [2:0] o);
    return (o <= OP_LBU);
  endfunction

  // Select the addressed lane of the read word and extend it for the op.
  function automatic logic [31:0] load_extend(input logic [2:0] o,
                                              input logic [31:0] w,
                                              input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (o)
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0000, h};
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h000000, b};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane of the old word with the store data.
  function automatic logic [31:0] store_merge(input logic [2:0] o,
                                              input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [1:0] lane);
    logic [31:0] m;
    m = old;
    if (o == OP_SB) begin
      m[{lane, 3'b000} +: 8] = wd[7:0];
    end else if (o == OP_SH) begin
      if (lane[1]) m[31:16] = wd[15:0];
      else         m[15:0]  = wd[15:0];
    end else begin
      m = wd;
    end
    return m;
  endfunction

  assign accept    = (state_q == S_IDLE) && req;
  assign state_dbg = state_q;

  // State register; reset aborts any in-flight access.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: misaligned goes straight to DONE, sub-word stores read first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (is_misaligned(op, addr[1:0])) state_d = S_DONE;
          else if (is_load(op))             state_d = S_READ;
          else if (op == OP_SW)             state_d = S_WRITE;
          else                              state_d = S_READ;
        end
      end
      S_READ:  state_d = is_load(op_q) ? S_DONE : S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    misalign  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    dataInput = 32'h0000_0000;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_READ: begin
        busy    = 1'b1;
        MemRead = 1'b1;
      end
      S_WRITE: begin
        busy      = 1'b1;
        MemWrite  = 1'b1;
        dataInput = (op_q == OP_SW) ? wdata_q : merged_q;
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        misalign = mis_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Word index comes from the latched address, zero-extended to 32 bits.
  assign dir = {{(32 - DEPTH_BITS){1'b0}}, addr_q[DEPTH_BITS+1:2]};

  // Access latch and read-side capture: loads update rdata, sub-word stores
  // build the merged word for the following WRITE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_LW;
      addr_q   <= '0;
      wdata_q  <= 32'h0000_0000;
      mis_q    <= 1'b0;
      merged_q <= 32'h0000_0000;
      rdata    <= 32'h0000_0000;
    end else begin
      if (accept) begin
        op_q    <= op;
        addr_q  <= addr[DEPTH_BITS+1:0];
        wdata_q <= wdata;
        mis_q   <= is_misaligned(op, addr[1:0]);
      end
      if (state_q == S_READ) begin
        if (is_load(op_q)) rdata <= load_extend(op_q, result, addr_q[1:0]);
        else               merged_q <= store_merge(op_q, result, wdata_q, addr_q[1:0]);
      end
    end
  end

endmodule
